mmio_bridge_mc: RTL and testbench

//  Parametrised MMIO bridge between the CPU memory stage and NUM_DEV peripheral windows.

---
 rtl/mmio_bridge_mc_pkg.sv | 31 +++
 rtl/mmio_bridge_mc_if.sv | 36 +++
 rtl/mmio_bridge_mc_addr_dec.sv | 41 ++++
 rtl/mmio_bridge_mc.sv | 210 +++++++++++++++++++++
 tb/tb_mmio_bridge_mc.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_bridge_mc_pkg.sv
// Shared definitions for the MMIO bridge: FSM states, error codes and
// width helpers used by the bridge top and its address decoder.
package mmio_bridge_mc_pkg;

   // Transaction FSM: idle, device access in flight, response pulse.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } bridge_state_e;

   // Reason a transaction completed; anything but ERR_NONE raises pr_err.
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_UNMAPPED = 2'd1;
   localparam logic [1:0] ERR_MISALIGN = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   // Ceiling log2, constant-foldable for parameter arithmetic.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Device index width; never zero so a single window still has a field.
   function automatic int idx_width(input int num_dev);
      return (num_dev > 1) ? clog2(num_dev) : 1;
   endfunction

endpackage

// File: rtl/mmio_bridge_mc_if.sv
// CPU-side and device-side signal bundle of the MMIO bridge.
// The bridge uses the slave view; the CPU/device environment uses master.
interface mmio_bridge_mc_if
   import mmio_bridge_mc_pkg::*;
#(
   parameter int NUM_DEV = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   logic                      pr_req;
   logic                      pr_we;
   logic [ADDR_W-1:0]         pr_addr;
   logic [DATA_W-1:0]         pr_wd;
   logic                      pr_busy;
   logic                      pr_ready;
   logic                      pr_err;
   logic [DATA_W-1:0]         pr_rd;
   logic [NUM_DEV-1:0]        dev_sel;
   logic                      dev_we;
   logic [ADDR_W-1:0]         dev_addr;
   logic [DATA_W-1:0]         dev_wd;
   logic [NUM_DEV-1:0]        dev_ack;
   logic [NUM_DEV*DATA_W-1:0] dev_rd;
   logic [NUM_DEV-1:0]        dev_irq;
   logic [NUM_DEV-1:0]        irq_out;

   modport slave (
      input  pr_req, pr_we, pr_addr, pr_wd, dev_ack, dev_rd, dev_irq,
      output pr_busy, pr_ready, pr_err, pr_rd, dev_sel, dev_we, dev_addr, dev_wd, irq_out
   );

   modport master (
      output pr_req, pr_we, pr_addr, pr_wd, dev_ack, dev_rd, dev_irq,
      input  pr_busy, pr_ready, pr_err, pr_rd, dev_sel, dev_we, dev_addr, dev_wd, irq_out
   );
endinterface

// File: rtl/mmio_bridge_mc_addr_dec.sv
// Combinational window decoder: maps a CPU byte address onto one of
// NUM_DEV equally spaced windows. Lowest index wins if windows overlap.
module mmio_addr_dec
   import mmio_bridge_mc_pkg::*;
#(
   parameter int          NUM_DEV    = 4,
   parameter int          ADDR_W     = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h7F00,
   parameter logic [31:0] DEV_STRIDE = 32'h10,
   parameter logic [31:0] DEV_SPAN   = 32'hC,
   localparam int         IDX_W      = idx_width(NUM_DEV)
)(
   input  logic [ADDR_W-1:0]  addr,
   output logic               hit,
   output logic [IDX_W-1:0]   idx,
   output logic [NUM_DEV-1:0] sel
);
   localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(DEV_STRIDE);
   localparam logic [ADDR_W-1:0] SPAN_A   = ADDR_W'(DEV_SPAN);

   logic [ADDR_W-1:0] off;
   logic [ADDR_W-1:0] lo;

   // Scan windows high to low so the lowest matching index is kept.
   always_comb begin
      off = addr - BASE_A;
      lo  = '0;
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         lo = STRIDE_A * ADDR_W'(i);
         if ((addr >= BASE_A) && (off >= lo) && (off < lo + SPAN_A)) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
      sel = '0;
      if (hit) sel[idx] = 1'b1;
   end
endmodule

// File: rtl/mmio_bridge_mc.sv
// MMIO bridge between the CPU memory stage and NUM_DEV device windows.
// One registered transaction per request; unmapped, misaligned or
// timed-out accesses complete with pr_err. Define BRIDGE_IRQ_EN to
// register dev_irq onto irq_out; otherwise irq_out is tied low.
module mmio_bridge_mc
   import mmio_bridge_mc_pkg::*;
#(
   parameter int          NUM_DEV    = 4,
   parameter int          ADDR_W     = 32,
   parameter int          DATA_W     = 32,
   parameter logic [31:0] BASE_ADDR  = 32'h7F00,
   parameter logic [31:0] DEV_STRIDE = 32'h10,
   parameter logic [31:0] DEV_SPAN   = 32'hC,
   parameter int          TIMEOUT    = 15
)(
   input logic             clk,
   input logic             reset_n,
   mmio_bridge_mc_if.slave bus
);
   localparam int               IDX_W    = idx_width(NUM_DEV);
   localparam int               CNT_W    = clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   if (DEV_SPAN > DEV_STRIDE) begin : g_chk_span
      $error("mmio_bridge_mc: DEV_SPAN must not exceed DEV_STRIDE");
   end
   if ((NUM_DEV < 1) || (NUM_DEV > 8)) begin : g_chk_ndev
      $error("mmio_bridge_mc: NUM_DEV must be 1..8");
   end
   if (TIMEOUT < 1) begin : g_chk_tmo
      $error("mmio_bridge_mc: TIMEOUT must be at least 1");
   end

   logic               dec_hit;
   logic [IDX_W-1:0]   dec_idx;
   logic [NUM_DEV-1:0] dec_sel;

   mmio_addr_dec #(
      .NUM_DEV    (NUM_DEV),
      .ADDR_W     (ADDR_W),
      .BASE_ADDR  (BASE_ADDR),
      .DEV_STRIDE (DEV_STRIDE),
      .DEV_SPAN   (DEV_SPAN)
   ) u_dec (
      .addr (bus.pr_addr),
      .hit  (dec_hit),
      .idx  (dec_idx),
      .sel  (dec_sel)
   );

   bridge_state_e      state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wd_q, wd_d;
   logic               we_q, we_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [NUM_DEV-1:0] sel_q, sel_d;
   logic               dev_we_q, dev_we_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         code_q, code_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               ready_q, ready_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  rd_q, rd_d;
   logic               busy_q, busy_d;
   logic               ack_hit;
   logic [DATA_W-1:0]  rd_sel;

   // Only the selected device's ack counts; stray acks are masked out.
   assign ack_hit = |(bus.dev_ack & sel_q);

   // Pick the read-data slice of the device being accessed.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (idx_q == IDX_W'(i)) rd_sel = bus.dev_rd[i*DATA_W +: DATA_W];
      end
   end

   // Next-state and next-output logic for the transaction FSM.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wd_d     = wd_q;
      we_d     = we_q;
      idx_d    = idx_q;
      sel_d    = sel_q;
      dev_we_d = dev_we_q;
      cnt_d    = cnt_q;
      code_d   = code_q;
      rdata_d  = rdata_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      rd_d     = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.pr_req) begin
               addr_d  = bus.pr_addr;
               wd_d    = bus.pr_wd;
               we_d    = bus.pr_we;
               idx_d   = dec_idx;
               cnt_d   = '0;
               rdata_d = '0;
               if (!dec_hit) begin
                  code_d  = ERR_UNMAPPED;
                  state_d = ST_RESP;
               end else if (bus.pr_addr[1:0] != 2'b00) begin
                  code_d  = ERR_MISALIGN;
                  state_d = ST_RESP;
               end else begin
                  code_d   = ERR_NONE;
                  sel_d    = dec_sel;
                  dev_we_d = bus.pr_we;
                  state_d  = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (ack_hit) begin
               code_d   = ERR_NONE;
               rdata_d  = we_q ? '0 : rd_sel;
               sel_d    = '0;
               dev_we_d = 1'b0;
               state_d  = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               code_d   = ERR_TIMEOUT;
               rdata_d  = '0;
               sel_d    = '0;
               dev_we_d = 1'b0;
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            ready_d  = 1'b1;
            err_d    = (code_q != ERR_NONE);
            rd_d     = rdata_q;
            sel_d    = '0;
            dev_we_d = 1'b0;
            state_d  = ST_IDLE;
         end
         default: begin
            sel_d    = '0;
            dev_we_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wd_q     <= '0;
         we_q     <= 1'b0;
         idx_q    <= '0;
         sel_q    <= '0;
         dev_we_q <= 1'b0;
         cnt_q    <= '0;
         code_q   <= ERR_NONE;
         rdata_q  <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         rd_q     <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wd_q     <= wd_d;
         we_q     <= we_d;
         idx_q    <= idx_d;
         sel_q    <= sel_d;
         dev_we_q <= dev_we_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         rd_q     <= rd_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.pr_busy  = busy_q;
   assign bus.pr_ready = ready_q;
   assign bus.pr_err   = err_q;
   assign bus.pr_rd    = rd_q;
   assign bus.dev_sel  = sel_q;
   assign bus.dev_we   = dev_we_q;
   assign bus.dev_addr = addr_q;
   assign bus.dev_wd   = wd_q;

`ifdef BRIDGE_IRQ_EN
   logic [NUM_DEV-1:0] irq_q, irq_d;
   assign irq_d = bus.dev_irq;

   // One-flop registration of the device interrupt lines.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq_q <= '0;
      else          irq_q <= irq_d;
   end

   assign bus.irq_out = irq_q;
`else
   assign bus.irq_out = '0;
`endif

endmodule

// File: tb/tb_mmio_bridge_mc.sv
// Self-checking bench for mmio_bridge_mc: directed cases followed by
// randomized transactions checked against an address/latency model.
module tb_mmio_bridge_mc;
   localparam int          NUM_DEV = 4;
   localparam int          TIMEOUT = 15;
   localparam logic [31:0] BASE    = 32'h7F00;
   localparam logic [31:0] STRIDE  = 32'h10;
   localparam logic [31:0] SPAN    = 32'hC;

   logic clk;
   logic reset_n;
   int   check_cnt;
   int   pass_cnt;
   logic [31:0] dev_data [NUM_DEV];

   mmio_bridge_mc_if #(.NUM_DEV(NUM_DEV), .ADDR_W(32), .DATA_W(32)) bus ();

   mmio_bridge_mc #(
      .NUM_DEV    (NUM_DEV),
      .ADDR_W     (32),
      .DATA_W     (32),
      .BASE_ADDR  (BASE),
      .DEV_STRIDE (STRIDE),
      .DEV_SPAN   (SPAN),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Device index hit by an address, or -1 when outside every window.
   function automatic int modelDecode(input logic [31:0] a);
      logic [31:0] off;
      int          d;
      if (a < BASE) return -1;
      off = a - BASE;
      if ((off / STRIDE) >= NUM_DEV) return -1;
      d = int'(off / STRIDE);
      if ((off % STRIDE) >= SPAN) return -1;
      return d;
   endfunction

   // One comparison: count it, count a pass, or report the failure.
   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   // Present a CPU request and fresh random read data on every device.
   task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic req);
      for (int i = 0; i < NUM_DEV; i++) begin
         dev_data[i] = $urandom;
         bus.dev_rd[i*32 +: 32] = dev_data[i];
      end
      bus.pr_addr = a;
      bus.pr_we   = w;
      bus.pr_wd   = d;
      bus.pr_req  = req;
   endtask

   // Full transaction: device responder acks during ACCESS cycle ack_n
   // (0 = never), with random acks on other devices as noise.
   task automatic runTransaction(input string tag, input logic [31:0] a, input logic w,
                                 input logic [31:0] d, input int ack_n, input int force_val);
      int          dev;
      bit          bad;
      int          exp_cycles;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [3:0]  exp_sel;
      int          cycles;
      bit          done;
      bit          sel_seen;
      logic [3:0]  noise;

      applyStimulus(a, w, d, 1'b1);
      dev = modelDecode(a);
      bad = (dev < 0) || (a[1:0] != 2'b00);
      if (!bad && force_val >= 0) begin
         dev_data[dev] = force_val;
         bus.dev_rd[dev*32 +: 32] = dev_data[dev];
      end
      exp_sel = bad ? 4'b0000 : (4'b0001 << dev);
      if (bad) begin
         exp_cycles = 2; exp_err = 1'b1; exp_rd = '0;
      end else if (ack_n >= 1 && ack_n <= TIMEOUT) begin
         exp_cycles = ack_n + 2; exp_err = 1'b0; exp_rd = w ? 32'h0 : dev_data[dev];
      end else begin
         exp_cycles = TIMEOUT + 2; exp_err = 1'b1; exp_rd = '0;
      end

      cycles   = 0;
      done     = 0;
      sel_seen = 0;
      while (!done && cycles < 40) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (bus.dev_sel != 4'b0000) sel_seen = 1;
         if (cycles == 1) begin
            checkOutput({tag, "_busy"}, bus.pr_busy, 1'b1);
            if (!bad) begin
               checkOutput({tag, "_sel"},  bus.dev_sel,  exp_sel);
               checkOutput({tag, "_we"},   bus.dev_we,   w);
               checkOutput({tag, "_addr"}, bus.dev_addr, a);
               if (w) checkOutput({tag, "_wd"}, bus.dev_wd, d);
            end
         end
         if (bus.pr_ready) begin
            done        = 1;
            bus.pr_req  = 1'b0;
            bus.dev_ack = '0;
            checkOutput({tag, "_latency"}, cycles, exp_cycles);
            checkOutput({tag, "_err"},     bus.pr_err, exp_err);
            checkOutput({tag, "_rd"},      bus.pr_rd,  exp_rd);
         end else begin
            noise = 4'($urandom);
            if (!bad) noise[dev] = (cycles == ack_n);
            bus.dev_ack = noise;
         end
      end
      if (!done) begin
         bus.pr_req  = 1'b0;
         bus.dev_ack = '0;
         checkOutput({tag, "_ready_seen"}, 1'b0, 1'b1);
      end
      if (bad) checkOutput({tag, "_sel_never"}, sel_seen, 1'b0);
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_pulse_end"}, {bus.pr_ready, bus.pr_busy}, 2'b00);
   endtask

   // Directed sequence, reset/irq checks, then randomized transactions.
   initial begin
      logic [31:0] ra;
      bit          seen;
      int          kind;
      check_cnt   = 0;
      pass_cnt    = 0;
      reset_n     = 1'b0;
      bus.pr_req  = 1'b0;
      bus.pr_we   = 1'b0;
      bus.pr_addr = '0;
      bus.pr_wd   = '0;
      bus.dev_ack = '0;
      bus.dev_rd  = '0;
      bus.dev_irq = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy",  bus.pr_busy,  1'b0);
      checkOutput("rst_ready", bus.pr_ready, 1'b0);
      checkOutput("rst_err",   bus.pr_err,   1'b0);
      checkOutput("rst_rd",    bus.pr_rd,    32'h0);
      checkOutput("rst_sel",   bus.dev_sel,  4'h0);
      checkOutput("rst_we",    bus.dev_we,   1'b0);
      checkOutput("rst_irq",   bus.irq_out,  4'h0);
      reset_n = 1'b1;
      @(negedge clk);

      runTransaction("rd_dev0",    32'h7F04, 1'b0, 32'h0,  1, 32'h1234);
      runTransaction("wr_dev1",    32'h7F14, 1'b1, 32'hA5, 2, -1);
      runTransaction("unmapped",   32'h7F0C, 1'b0, 32'h0,  1, -1);
      runTransaction("misalign",   32'h7F02, 1'b0, 32'h0,  1, -1);
      runTransaction("timeout",    32'h7F20, 1'b0, 32'h0,  0, -1);
      runTransaction("late_ack",   32'h7F20, 1'b0, 32'h0, 15, -1);
      runTransaction("above_last", 32'h7F40, 1'b0, 32'h0,  1, -1);
      runTransaction("below_base", 32'h7EFC, 1'b0, 32'h0,  1, -1);
      runTransaction("rd_dev3",    32'h7F38, 1'b0, 32'h0,  4, -1);

      $display("[TB] reset during ACCESS");
      applyStimulus(32'h7F20, 1'b0, 32'h0, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("mid_sel", bus.dev_sel, 4'b0100);
      #2;
      reset_n    = 1'b0;
      bus.pr_req = 1'b0;
      #1;
      checkOutput("async_rst_sel",   bus.dev_sel,  4'h0);
      checkOutput("async_rst_ready", bus.pr_ready, 1'b0);
      checkOutput("async_rst_busy",  bus.pr_busy,  1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.pr_ready || bus.pr_busy) seen = 1;
      end
      checkOutput("post_rst_quiet", seen, 1'b0);

      $display("[TB] interrupt path");
      bus.dev_irq = 4'b1001;
      @(posedge clk);
      #1;
`ifdef BRIDGE_IRQ_EN
      checkOutput("irq_reg", bus.irq_out, 4'b1001);
`else
      checkOutput("irq_off", bus.irq_out, 4'b0000);
`endif
      @(negedge clk);
      bus.dev_irq = 4'b0000;

      $display("[TB] randomized transactions");
      for (int t = 0; t < 24; t++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) ra = BASE - 32'($urandom_range(1, 64));
         else           ra = BASE + 32'($urandom_range(0, 5)) * STRIDE + 32'($urandom_range(0, 15));
         if (kind > 3) ra[1:0] = 2'b00;
         runTransaction("rand", ra, 1'($urandom), $urandom, $urandom_range(0, 16), -1);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end
endmodule
